// File: rtl/float_discriminant_mc_if.sv
// rtl/float_discriminant_mc_if.sv - request/result bundle plus shared FP-unit handshake for float_discriminant_mc
interface float_discriminant_mc_if #(
    parameter int FLEN = 64,
    parameter int N_CH = 4,
    parameter int CH_W = $clog2(N_CH)
);
    logic [N_CH-1:0]      arg_vld;
    logic [N_CH-1:0]      arg_rdy;
    logic [N_CH*FLEN-1:0] a;
    logic [N_CH*FLEN-1:0] b;
    logic [N_CH*FLEN-1:0] c;
    logic                 res_vld;
    logic [CH_W-1:0]      res_ch;
    logic [FLEN-1:0]      res;
    logic                 res_negative;
    logic                 err;
    logic                 busy;

    // Shared multiplier and subtractor, one operation in flight at a time
    logic                 mul_up_valid;
    logic [FLEN-1:0]      mul_op_a;
    logic [FLEN-1:0]      mul_op_b;
    logic                 mul_down_valid;
    logic [FLEN-1:0]      mul_result;
    logic                 mul_error;
    logic                 sub_up_valid;
    logic [FLEN-1:0]      sub_op_a;
    logic [FLEN-1:0]      sub_op_b;
    logic                 sub_down_valid;
    logic [FLEN-1:0]      sub_result;
    logic                 sub_error;

    modport master (
        output arg_vld, a, b, c,
        input  arg_rdy, res_vld, res_ch, res, res_negative, err, busy,
        input  mul_up_valid, mul_op_a, mul_op_b,
        output mul_down_valid, mul_result, mul_error,
        input  sub_up_valid, sub_op_a, sub_op_b,
        output sub_down_valid, sub_result, sub_error
    );

    modport slave (
        input  arg_vld, a, b, c,
        output arg_rdy, res_vld, res_ch, res, res_negative, err, busy,
        output mul_up_valid, mul_op_a, mul_op_b,
        input  mul_down_valid, mul_result, mul_error,
        output sub_up_valid, sub_op_a, sub_op_b,
        input  sub_down_valid, sub_result, sub_error
    );
endinterface

// File: rtl/float_discriminant_mc.sv
// rtl/float_discriminant_mc.sv - round-robin N_CH-channel b*b-4ac engine over one shared f_mult/f_sub
module float_discriminant_mc #(
    parameter int FLEN = 64,
    parameter int N_CH = 4,
    parameter int CH_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    float_discriminant_mc_if.slave io
);
    localparam logic [FLEN-1:0] FP_FOUR = 64'h4010_0000_0000_0000;

    typedef enum logic [2:0] {IDLE, MUL_BB, MUL_4A, MUL_4AC, SUB, ERR_OUT} state_t;

    state_t          state, state_d;
    logic [FLEN-1:0] a_q [N_CH];
    logic [FLEN-1:0] b_q [N_CH];
    logic [FLEN-1:0] c_q [N_CH];
    logic [N_CH-1:0] pend, cap, grant_oh;
    logic [CH_W-1:0] last_grant, grant, res_ch_q;
    logic            grant_vld, take, grant_inv;
    logic            issue, job_err, job_err_d, mul_done, sub_done;
    logic [FLEN-1:0] wa, wb, wc, bb, a4, ac4;

    function automatic logic [CH_W-1:0] ch_after(input logic [CH_W-1:0] base, input int k);
        int s;
        s = (int'(base) + k) % N_CH;
        return CH_W'(s);
    endfunction

    // Scan from farthest to nearest so the nearest pending channel after last_grant wins
    always_comb begin
        grant     = last_grant;
        grant_vld = 1'b0;
        for (int k = N_CH; k >= 1; k--) begin
            if (pend[ch_after(last_grant, k)]) begin
                grant     = ch_after(last_grant, k);
                grant_vld = 1'b1;
            end
        end
    end

    assign take      = (state == IDLE) && grant_vld;
    assign grant_inv = (&a_q[grant][62:52]) | (&b_q[grant][62:52]) | (&c_q[grant][62:52]);
    assign cap       = io.arg_vld & ~pend;
    assign grant_oh  = take ? ({{(N_CH-1){1'b0}}, 1'b1} << grant) : '0;
    assign mul_done  = io.mul_down_valid && (state inside {MUL_BB, MUL_4A, MUL_4AC});
    assign sub_done  = io.sub_down_valid && (state == SUB);
    assign job_err_d = job_err | (mul_done & io.mul_error) | (sub_done & io.sub_error);

    assign io.arg_rdy = ~pend;
    assign io.busy    = (|pend) | (state != IDLE);

    always_comb begin
        state_d         = state;
        io.mul_up_valid = 1'b0;
        io.mul_op_a     = wb;
        io.mul_op_b     = wb;
        io.sub_up_valid = 1'b0;
        io.sub_op_a     = bb;
        io.sub_op_b     = ac4;
        case (state)
            IDLE: begin
                if (take) state_d = grant_inv ? ERR_OUT : MUL_BB;
            end
            MUL_BB: begin
                io.mul_up_valid = issue;
                if (mul_done) state_d = MUL_4A;
            end
            MUL_4A: begin
                io.mul_up_valid = issue;
                io.mul_op_a     = FP_FOUR;
                io.mul_op_b     = wa;
                if (mul_done) state_d = MUL_4AC;
            end
            MUL_4AC: begin
                io.mul_up_valid = issue;
                io.mul_op_a     = a4;
                io.mul_op_b     = wc;
                if (mul_done) state_d = SUB;
            end
            SUB: begin
                io.sub_up_valid = issue;
                if (sub_done) state_d = IDLE;
            end
            ERR_OUT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            pend            <= '0;
            last_grant      <= CH_W'(N_CH - 1);
            res_ch_q        <= '0;
            issue           <= 1'b0;
            job_err         <= 1'b0;
            io.res_vld      <= 1'b0;
            io.res          <= '0;
            io.res_ch       <= '0;
            io.err          <= 1'b0;
            io.res_negative <= 1'b0;
        end else begin
            state      <= state_d;
            // Unit requests fire only on the first cycle of each arithmetic state
            issue      <= (state_d != state) && (state_d inside {MUL_BB, MUL_4A, MUL_4AC, SUB});
            pend       <= (pend | cap) & ~grant_oh;
            job_err    <= take ? 1'b0 : job_err_d;
            io.res_vld <= 1'b0;
            if (take) begin
                last_grant <= grant;
                res_ch_q   <= grant;
            end
            if (take && grant_inv) begin
                io.res_vld      <= 1'b1;
                io.res          <= '0;
                io.err          <= 1'b1;
                io.res_ch       <= grant;
                io.res_negative <= 1'b0;
            end else if (sub_done) begin
                io.res_vld      <= 1'b1;
                io.res          <= job_err_d ? '0 : io.sub_result;
                io.err          <= job_err_d;
                io.res_ch       <= res_ch_q;
                io.res_negative <= !job_err_d && io.sub_result[FLEN-1] && (|io.sub_result[FLEN-2:0]);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (cap[i]) begin
                a_q[i] <= io.a[i*FLEN +: FLEN];
                b_q[i] <= io.b[i*FLEN +: FLEN];
                c_q[i] <= io.c[i*FLEN +: FLEN];
            end
        end
        if (take) begin
            wa <= a_q[grant];
            wb <= b_q[grant];
            wc <= c_q[grant];
        end
        if (mul_done && state == MUL_BB)  bb  <= io.mul_result;
        if (mul_done && state == MUL_4A)  a4  <= io.mul_result;
        if (mul_done && state == MUL_4AC) ac4 <= io.mul_result;
    end
endmodule

// File: tb/tb_float_discriminant_mc.sv
// tb/tb_float_discriminant_mc.sv - directed and randomized checks of float_discriminant_mc against a real-arithmetic model
module tb_float_discriminant_mc;
    localparam int LM  = 3;
    localparam int LS  = 2;
    localparam int LAT = 2 + 3 * (LM + 1) + (LS + 1);
    localparam logic [63:0] ONE = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] TWO = 64'h4000_0000_0000_0000;
    localparam logic [63:0] THREE = 64'h4008_0000_0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    float_discriminant_mc_if #(.FLEN(64), .N_CH(4)) io ();
    float_discriminant_mc #(.FLEN(64), .N_CH(4)) dut (.clk(clk), .rst(rst), .io(io));

    // Stand-in FP units: IEEE double arithmetic with fixed latency, error on Inf/NaN result
    int          mul_issues = 0;
    int          overlap = 0;
    int          m_cnt = 0;
    int          s_cnt = 0;
    logic        m_out = 1'b0;
    logic        s_out = 1'b0;
    logic [63:0] m_res = '0;
    logic [63:0] s_res = '0;
    assign io.mul_result = m_res;
    assign io.mul_error  = &m_res[62:52];
    assign io.sub_result = s_res;
    assign io.sub_error  = &s_res[62:52];

    always @(posedge clk) begin
        if (rst) begin
            io.mul_down_valid <= 1'b0;
            io.sub_down_valid <= 1'b0;
            m_cnt <= 0; s_cnt <= 0; m_out <= 1'b0; s_out <= 1'b0;
        end else begin
            io.mul_down_valid <= 1'b0;
            io.sub_down_valid <= 1'b0;
            if (io.mul_down_valid) m_out <= 1'b0;
            if (io.sub_down_valid) s_out <= 1'b0;
            if ((io.mul_up_valid || io.sub_up_valid) &&
                (m_out || s_out || (io.mul_up_valid && io.sub_up_valid)))
                overlap <= overlap + 1;
            if (io.mul_up_valid) begin
                mul_issues <= mul_issues + 1;
                m_out <= 1'b1;
                m_res <= $realtobits($bitstoreal(io.mul_op_a) * $bitstoreal(io.mul_op_b));
                if (LM == 1) io.mul_down_valid <= 1'b1; else m_cnt <= LM - 1;
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) io.mul_down_valid <= 1'b1;
            end
            if (io.sub_up_valid) begin
                s_out <= 1'b1;
                s_res <= $realtobits($bitstoreal(io.sub_op_a) - $bitstoreal(io.sub_op_b));
                if (LS == 1) io.sub_down_valid <= 1'b1; else s_cnt <= LS - 1;
            end else if (s_cnt != 0) begin
                s_cnt <= s_cnt - 1;
                if (s_cnt == 1) io.sub_down_valid <= 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void ref_disc(input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                                     output logic [63:0] r, output bit e, output bit inv);
        real bb, a4, ac4, d;
        logic [63:0] bbb, a4b, ac4b, db;
        inv  = (&va[62:52]) || (&vb[62:52]) || (&vc[62:52]);
        bb   = $bitstoreal(vb) * $bitstoreal(vb);
        a4   = 4.0 * $bitstoreal(va);
        ac4  = a4 * $bitstoreal(vc);
        d    = bb - ac4;
        bbb  = $realtobits(bb);
        a4b  = $realtobits(a4);
        ac4b = $realtobits(ac4);
        db   = $realtobits(d);
        e    = inv || (&bbb[62:52]) || (&a4b[62:52]) || (&ac4b[62:52]) || (&db[62:52]);
        r    = e ? 64'h0 : db;
    endfunction

    function automatic logic [63:0] rnd_fp();
        logic [63:0] v, m;
        m = {$urandom, $urandom};
        v[63]    = 1'($urandom_range(0, 1));
        v[62:52] = 11'(1003 + $urandom_range(0, 40));
        v[51:0]  = m[51:0];
        return v;
    endfunction

    task automatic send(input int ch, input logic [63:0] va, input logic [63:0] vb,
                        input logic [63:0] vc, output int t);
        @(negedge clk);
        io.a[ch*64 +: 64] = va;
        io.b[ch*64 +: 64] = vb;
        io.c[ch*64 +: 64] = vc;
        io.arg_vld[ch[1:0]] = 1'b1;
        t = cyc;
        @(posedge clk);
        #1;
        io.arg_vld[ch[1:0]] = 1'b0;
    endtask

    task automatic wait_res(input int max, output int at, output bit ok);
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < max; i++) begin
            if (io.res_vld === 1'b1) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_job(input int ch, input logic [63:0] va, input logic [63:0] vb,
                           input logic [63:0] vc, input string tag);
        logic [63:0] er;
        bit ee, inv, ok;
        int t, at;
        ref_disc(va, vb, vc, er, ee, inv);
        send(ch, va, vb, vc, t);
        check({tag, "_rdy_low"}, io.arg_rdy[ch[1:0]], 1'b0);
        @(negedge clk);
        @(negedge clk);
        check({tag, "_rdy_back"}, io.arg_rdy[ch[1:0]], 1'b1);
        check({tag, "_busy"}, io.busy, 1'b1);
        wait_res(LAT + 20, at, ok);
        check({tag, "_seen"}, ok, 1'b1);
        if (ok) begin
            check({tag, "_latency"}, at, t + (inv ? 2 : LAT));
            check({tag, "_ch"}, io.res_ch, ch);
            check({tag, "_err"}, io.err, ee);
            if (er[62:0] == 63'h0) check({tag, "_res_mag"}, io.res[62:0], er[62:0]);
            else                   check({tag, "_res"}, io.res, er);
            check({tag, "_neg"}, io.res_negative, er[63] & (|er[62:0]));
        end
    endtask

    logic [63:0] exp_r [4][3];
    bit          exp_e [4][3];
    int          sent [4];
    int          got [4];
    bit          drove [4];

    initial begin
        int m0, t, nres, prev_at, exp_ch, busy_bad, rdy_bad, nstale, ch;
        bit started, inv;
        logic [63:0] va, vb, vc;

        io.arg_vld = '0; io.a = '0; io.b = '0; io.c = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_rdy", io.arg_rdy, 4'hF);
        check("rst_busy", io.busy, 1'b0);
        check("rst_vld", io.res_vld, 1'b0);
        check("rst_res", io.res, 64'h0);
        check("rst_err", io.err, 1'b0);
        check("rst_ch", io.res_ch, 2'd0);
        check("rst_neg", io.res_negative, 1'b0);

        run_job(0, ONE, THREE, TWO, "ch0_pos");
        check("ch0_const", io.res, 64'h3FF0_0000_0000_0000);
        run_job(2, ONE, TWO, TWO, "ch2_neg");
        check("ch2_const", io.res, 64'hC010_0000_0000_0000);
        check("ch2_neg_const", io.res_negative, 1'b1);
        run_job(1, ONE, TWO, ONE, "ch1_zero");
        check("ch1_zero_const", io.res[62:0], 63'h0);

        m0 = mul_issues;
        run_job(3, 64'h7FF0_0000_0000_0000, TWO, TWO, "ch3_inf");
        check("ch3_inf_const_err", io.err, 1'b1);
        run_job(3, ONE, 64'h7FF8_0000_0000_0000, ONE, "ch3_nan");
        repeat (3) @(negedge clk);
        check("inv_no_mul", mul_issues, m0);

        run_job(0, ONE, $realtobits(1.0e200), ONE, "ovf");
        for (int i = 0; i < 4; i++) run_job($urandom_range(0, 3), rnd_fp(), rnd_fp(), rnd_fp(), "rnd");

        // Reset in the middle of a job with two more channels waiting
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            io.a[i*64 +: 64] = rnd_fp();
            io.b[i*64 +: 64] = rnd_fp();
            io.c[i*64 +: 64] = rnd_fp();
        end
        io.arg_vld = 4'b0111;
        @(posedge clk);
        #1;
        io.arg_vld = '0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_rdy", io.arg_rdy, 4'hF);
        check("mid_rst_busy", io.busy, 1'b0);
        check("mid_rst_vld", io.res_vld, 1'b0);
        nstale = 0;
        repeat (40) begin
            @(negedge clk);
            if (io.res_vld === 1'b1) nstale++;
        end
        check("mid_rst_stale", nstale, 0);
        run_job(3, rnd_fp(), rnd_fp(), rnd_fp(), "post_rst");

        // All channels request together and re-request as soon as ready returns
        for (int i = 0; i < 4; i++) begin sent[i] = 0; got[i] = 0; drove[i] = 1'b0; end
        nres = 0; prev_at = -1; exp_ch = 0; busy_bad = 0; rdy_bad = 0; started = 1'b0;
        for (int cy = 0; cy < 600 && nres < 12; cy++) begin
            @(negedge clk);
            if (io.res_vld === 1'b1) begin
                ch = int'(io.res_ch);
                check("burst_ch", io.res_ch, exp_ch);
                if (got[ch] < 3) begin
                    check("burst_res", io.res, exp_r[ch][got[ch]]);
                    check("burst_err", io.err, exp_e[ch][got[ch]]);
                end
                if (prev_at >= 0) check("burst_gap", cyc - prev_at, 3 * (LM + 1) + (LS + 1) + 1);
                prev_at = cyc;
                got[ch]++;
                nres++;
                exp_ch = (exp_ch + 1) % 4;
                if (nres == 12) check("burst_busy_end", io.busy, 1'b0);
            end else if (started && io.busy !== 1'b1) begin
                busy_bad++;
            end
            for (int i = 0; i < 4; i++) begin
                if (drove[i] && io.arg_rdy[i] !== 1'b0) rdy_bad++;
                drove[i] = 1'b0;
                if (io.arg_rdy[i] && sent[i] < 3 && nres < 12) begin
                    va = rnd_fp(); vb = rnd_fp(); vc = rnd_fp();
                    io.a[i*64 +: 64] = va;
                    io.b[i*64 +: 64] = vb;
                    io.c[i*64 +: 64] = vc;
                    ref_disc(va, vb, vc, exp_r[i][sent[i]], exp_e[i][sent[i]], inv);
                    io.arg_vld[i] = 1'b1;
                    drove[i] = 1'b1;
                    sent[i]++;
                    started = 1'b1;
                end else begin
                    io.arg_vld[i] = 1'b0;
                end
            end
        end
        io.arg_vld = '0;
        check("burst_count", nres, 12);
        check("burst_busy", busy_bad, 0);
        check("burst_rdy_low", rdy_bad, 0);
        check("one_outstanding", overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
